reparam_layer: RTL and testbench

Reparameterization stage of the latent path: computes z[i] = mu[i] + sigma[i]·eps[i] for all HID_DIM elements. It is the consuming end of the random-layer handshake. It drives `rand_run` to the random layer, waits for `rand_valid`, latches the packed eps vector, and runs one shared multiplier sequentially over the elements. The packed z vector goes to the decoder with a level `valid`.

---
 rtl/reparam_layer.sv | 124 ++++++++++++
 tb/tb_reparam_layer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reparam_layer.sv
// Reparameterization stage: z[i] = mu[i] + sigma[i]*eps[i], computed one element per cycle
// on a shared multiplier after eps has been fetched from the random layer.
module reparam_layer #(
  parameter int HID_DIM = 24,
  parameter int N_LEN   = 16,
  parameter int F_LEN   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [HID_DIM*N_LEN-1:0] mu,
  input  logic [HID_DIM*N_LEN-1:0] sigma,
  output logic                     rand_run,
  input  logic                     rand_valid,
  input  logic [HID_DIM*N_LEN-1:0] rand_q,
  output logic                     valid,
  output logic [HID_DIM*N_LEN-1:0] q
);

  localparam int IDX_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int P_W   = 2 * N_LEN;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HID_DIM - 1);
  localparam logic signed [P_W-1:0] SAT_HI = {{(N_LEN + 1){1'b0}}, {(N_LEN - 1){1'b1}}};
  localparam logic signed [P_W-1:0] SAT_LO = {{(N_LEN + 1){1'b1}}, {(N_LEN - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_RAND, CALC, DONE} state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [HID_DIM*N_LEN-1:0]   eps_q;
  logic [HID_DIM*N_LEN-1:0]   q_q;
  logic                       rand_run_q;
  logic                       valid_q;

  logic signed [N_LEN-1:0]    mu_e;
  logic signed [N_LEN-1:0]    sig_e;
  logic signed [N_LEN-1:0]    eps_e;
  logic signed [P_W-1:0]      prod;
  logic signed [P_W-1:0]      shifted;
  logic signed [P_W-1:0]      sum;
  logic [N_LEN-1:0]           elem_d;

  // Datapath for the element currently addressed by idx_q; the product carries
  // enough headroom that shifted + mu cannot wrap before saturation.
  always_comb begin
    mu_e    = mu[int'(idx_q) * N_LEN +: N_LEN];
    sig_e   = sigma[int'(idx_q) * N_LEN +: N_LEN];
    eps_e   = eps_q[int'(idx_q) * N_LEN +: N_LEN];
    prod    = sig_e * eps_e;
    shifted = prod >>> F_LEN;
    sum     = shifted + $signed({{N_LEN{mu_e[N_LEN-1]}}, mu_e});
    elem_d  = sum[N_LEN-1:0];
    if (sum > SAT_HI) begin
      elem_d = SAT_HI[N_LEN-1:0];
    end else if (sum < SAT_LO) begin
      elem_d = SAT_LO[N_LEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      eps_q      <= '0;
      q_q        <= '0;
      rand_run_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q      <= '0;
          valid_q    <= 1'b0;
          rand_run_q <= 1'b0;
          if (run) begin
            state_q    <= WAIT_RAND;
            rand_run_q <= 1'b1;
          end
        end
        WAIT_RAND: begin
          if (!run) begin
            state_q    <= IDLE;
            rand_run_q <= 1'b0;
          end else if (rand_valid) begin
            eps_q      <= rand_q;
            idx_q      <= '0;
            state_q    <= CALC;
            rand_run_q <= 1'b0;
          end
        end
        CALC: begin
          if (!run) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            q_q[int'(idx_q) * N_LEN +: N_LEN] <= elem_d;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (!run) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          rand_run_q <= 1'b0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rand_run = rand_run_q;
  assign valid    = valid_q;
  assign q        = q_q;

endmodule

// File: tb/tb_reparam_layer.sv
// Self-checking bench for reparam_layer: stub random layer, per-element arithmetic model,
// continuous compare of q whenever valid is high, plus directed handshake/latency checks.
module tb_reparam_layer;

  localparam int HD = 24;
  localparam int NL = 16;
  localparam int FL = 8;
  localparam int W  = HD * NL;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic [W-1:0] mu;
  logic [W-1:0] sigma;
  logic         rand_run;
  logic         rand_valid;
  logic [W-1:0] rand_q;
  logic         valid;
  logic [W-1:0] q;

  always #5 clk = ~clk;

  reparam_layer #(.HID_DIM(HD), .N_LEN(NL), .F_LEN(FL)) dut (
    .clk(clk), .rst(rst), .run(run), .mu(mu), .sigma(sigma),
    .rand_run(rand_run), .rand_valid(rand_valid), .rand_q(rand_q),
    .valid(valid), .q(q)
  );

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q;
  bit           exp_ok = 1'b0;
  int           rdelay = 3;
  bit           force_valid = 1'b0;
  int           rcnt = 0;

  // z = sat(floor(sigma*eps / 2^FL) + mu), all values signed NL-bit
  function automatic logic [NL-1:0] zmod(input logic [NL-1:0] m, input logic [NL-1:0] s,
                                         input logic [NL-1:0] e);
    longint p;
    longint t;
    p = longint'($signed(s)) * longint'($signed(e));
    t = (p >>> FL) + longint'($signed(m));
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
    return NL'(t);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, expv);
    end
  endtask

  // Stub random layer: raises rand_valid rdelay cycles after rand_run, holds while rand_run high.
  initial begin
    rand_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_valid) rand_valid = 1'b1;
      else if (!rand_run) begin
        rcnt = 0;
        rand_valid = 1'b0;
      end else if (rcnt >= rdelay) rand_valid = 1'b1;
      else begin
        rand_valid = 1'b0;
        rcnt++;
      end
    end
  end

  // Continuous compare: whenever valid is high, the full z vector must match the model.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (valid === 1'b1) begin
        checks++;
        if (!exp_ok) begin
          errors++;
          $display("FAIL unexpected_valid got 1 want 0");
        end else if (q !== exp_q) begin
          errors++;
          $display("FAIL cmp_q got %h want %h", q, exp_q);
        end
      end
    end
  end

  task automatic load(input int pat);
    logic [NL-1:0] m, s, e;
    for (int i = 0; i < HD; i++) begin
      case (pat)
        0: begin m = 16'h0100; s = 16'h0100; e = 16'h0080; end
        1: begin m = 16'h0000; s = (i % 2 == 0) ? 16'h0100 : 16'h0001; e = 16'hFFFF; end
        2: if (i % 2 == 0) begin m = 16'h7F00; s = 16'h7FFF; e = 16'h7FFF; end
           else begin m = 16'h8000; s = 16'h7FFF; e = 16'h8000; end
        3: begin m = NL'(i * 256); s = 16'h0100; e = NL'(i); end
        default: begin
          m = NL'($urandom);
          s = ($urandom_range(0, 1) == 0) ? NL'($urandom) : NL'($urandom_range(0, 1023)) - 16'd512;
          e = ($urandom_range(0, 1) == 0) ? NL'($urandom) : NL'($urandom_range(0, 1023)) - 16'd512;
        end
      endcase
      mu[i*NL +: NL]     = m;
      sigma[i*NL +: NL]  = s;
      rand_q[i*NL +: NL] = e;
      exp_q[i*NL +: NL]  = zmod(m, s, e);
    end
  endtask

  task automatic do_txn(input int delay, input bit fv, input bit scramble);
    int n, ev;
    bit got;
    rdelay = delay;
    force_valid = fv;
    @(negedge clk);
    exp_ok = 1'b1;
    run = 1'b1;
    n = 0; ev = 0; got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (ev == 0 && rand_run && rand_valid) ev = n + 1;
      @(negedge clk);
      n++;
      if (n == 1) check("rand_run_rise", W'(rand_run), W'(1));
      if (scramble && ev != 0 && !rand_run)
        for (int i = 0; i < HD; i++) rand_q[i*NL +: NL] = NL'($urandom);
      got = valid;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got 0 want 1");
    end else if (fv) check("latency_total", W'(n), W'(HD + 2));
    else check("latency_from_rand_valid", W'(n - ev), W'(HD));
    @(negedge clk);
    check("valid_hold", W'(valid), W'(1));
    exp_ok = 1'b0;
    run = 1'b0;
    @(negedge clk);
    check("valid_drop", W'(valid), W'(0));
    force_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_calc(output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (!rand_run && c < 100) begin @(negedge clk); c++; end
    while (rand_run && c < 100) begin @(negedge clk); c++; end
    ok = (c < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL calc_entry_timeout got %0d want <100", c);
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; run = 1'b0; mu = '0; sigma = '0; rand_q = '0; exp_q = '0;
    repeat (2) @(negedge clk);
    check("reset_q", q, '0);
    check("reset_valid", W'(valid), W'(0));
    check("reset_rand_run", W'(rand_run), W'(0));
    rst = 1'b0;

    check("model_basic", W'(zmod(16'h0100, 16'h0100, 16'h0080)), W'(16'h0180));
    check("model_neg", W'(zmod(16'h0000, 16'h0100, 16'hFFFF)), W'(16'hFFFF));
    check("model_floor", W'(zmod(16'h0000, 16'h0001, 16'hFFFF)), W'(16'hFFFF));
    check("model_sat_hi", W'(zmod(16'h7F00, 16'h7FFF, 16'h7FFF)), W'(16'h7FFF));
    check("model_sat_lo", W'(zmod(16'h8000, 16'h7FFF, 16'h8000)), W'(16'h8000));

    load(0); do_txn(3, 1'b0, 1'b0);
    check("basic_q0", W'(q[0 +: NL]), W'(16'h0180));
    check("basic_q23", W'(q[23*NL +: NL]), W'(16'h0180));
    load(1); do_txn(3, 1'b0, 1'b0);
    check("neg_q0", W'(q[0 +: NL]), W'(16'hFFFF));
    check("floor_q1", W'(q[NL +: NL]), W'(16'hFFFF));
    load(2); do_txn(1, 1'b0, 1'b0);
    check("sat_hi_q0", W'(q[0 +: NL]), W'(16'h7FFF));
    check("sat_lo_q1", W'(q[NL +: NL]), W'(16'h8000));
    load(3); do_txn(0, 1'b1, 1'b0);
    check("index_q5", W'(q[5*NL +: NL]), W'(16'h0505));
    check("index_q23", W'(q[23*NL +: NL]), W'(16'h1717));

    // abort while waiting for eps, then restart
    load(4); rdelay = 50;
    @(negedge clk); run = 1'b1;
    @(negedge clk); check("abort_wait_rr", W'(rand_run), W'(1));
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk); check("abort_wait_rr_drop", W'(rand_run), W'(0));
    repeat (30) @(negedge clk);
    check("abort_wait_no_valid", W'(valid), W'(0));
    load(4); do_txn(2, 1'b0, 1'b0);

    // abort mid-CALC: first five elements written, valid never rises
    load(4); rdelay = 1;
    @(negedge clk); run = 1'b1;
    wait_calc(ok);
    repeat (5) @(negedge clk);
    run = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_calc_no_valid", W'(valid), W'(0));
    if (ok) check("abort_calc_partial", W'(q[5*NL-1:0]), W'(exp_q[5*NL-1:0]));

    for (int k = 0; k < 8; k++) begin
      load(4);
      do_txn($urandom_range(0, 5), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    // asynchronous reset mid-CALC, then mid-WAIT_RAND
    load(4); rdelay = 1;
    @(negedge clk); run = 1'b1;
    wait_calc(ok);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", q, '0);
    check("async_rst_valid", W'(valid), W'(0));
    check("async_rst_rand_run", W'(rand_run), W'(0));
    rdelay = 50;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("rst_release_rr", W'(rand_run), W'(1));
    #2 rst = 1'b1;
    #1 check("async_rst_wait_rr", W'(rand_run), W'(0));
    run = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
